// File: rtl/stack_bus_pkg.sv
// Shared stack-bus framing codes, arbiter FSM encoding and default widths.
// Imported by the downstream arbiter and its round-robin picker.
package stack_bus_pkg;

  localparam int SB_NUM_PORTS     = 4;
  localparam int SB_DATA_WIDTH    = 64;
  localparam int SB_PORT_ID_WIDTH = 2;

  localparam int CNTL_SOP_BIT = 0;
  localparam int CNTL_EOP_BIT = 1;

  typedef enum logic [1:0] {
    CNTL_MOP     = 2'b00,
    CNTL_SOP     = 2'b01,
    CNTL_EOP     = 2'b10,
    CNTL_SOP_EOP = 2'b11
  } sb_cntl_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  function automatic logic cntl_sop(input logic [1:0] c);
    return c[CNTL_SOP_BIT];
  endfunction

  function automatic logic cntl_eop(input logic [1:0] c);
    return c[CNTL_EOP_BIT];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer,
// wrapping from the top port back to port 0.
module rr_arbiter
  import stack_bus_pkg::*;
#(
  parameter int N = SB_NUM_PORTS,
  parameter int W = SB_PORT_ID_WIDTH
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic found;
  int   pos;

  // scan ports starting at the pointer, keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(pointer) + i) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = W'(pos);
      end
    end
  end

endmodule

// File: rtl/stack_bus_downstream_arbiter.sv
// Packet-locked round-robin merge of manager streams onto the stack bus.
// Optional per-port EOP counters: STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN.
module stack_bus_downstream_arbiter
  import stack_bus_pkg::*;
#(
  parameter int NUM_PORTS     = SB_NUM_PORTS,
  parameter int DATA_WIDTH    = SB_DATA_WIDTH,
  parameter int PORT_ID_WIDTH = SB_PORT_ID_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic [NUM_PORTS-1:0]            mgr__arb__valid,
  input  logic [2*NUM_PORTS-1:0]          mgr__arb__cntl,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] mgr__arb__data,
  output logic [NUM_PORTS-1:0]            arb__mgr__ready,
  output logic                            arb__sb__valid,
  output logic [1:0]                      arb__sb__cntl,
  output logic [DATA_WIDTH-1:0]           arb__sb__data,
  output logic [PORT_ID_WIDTH-1:0]        arb__sb__port,
  input  logic                            sb__arb__ready,
  output logic                            arb__sys__busy
`ifdef STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]         arb__sys__pkt_cnt
`endif
);

  arb_state_e               state;
  logic [PORT_ID_WIDTH-1:0] ptr;
  logic [PORT_ID_WIDTH-1:0] lock;

  logic [NUM_PORTS-1:0]     sop_req;
  logic [NUM_PORTS-1:0]     rr_grant;
  logic [PORT_ID_WIDTH-1:0] rr_idx;
  logic [NUM_PORTS-1:0]     sel_oh;
  logic [PORT_ID_WIDTH-1:0] sel_idx;
  logic [PORT_ID_WIDTH-1:0] nxt_ptr;
  logic [NUM_PORTS-1:0]     take;
  logic                     can_load;
  logic                     accept;
  logic [1:0]               sel_cntl;
  logic [DATA_WIDTH-1:0]    sel_data;

  // only ports opening a packet may win a fresh grant
  always_comb begin
    sop_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sop_req[i] = mgr__arb__valid[i] &
                   cntl_sop(mgr__arb__cntl[2*i +: 2]);
    end
  end

  rr_arbiter #(
    .N (NUM_PORTS),
    .W (PORT_ID_WIDTH)
  ) u_rr (
    .req       (sop_req),
    .pointer   (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // served port is the locked one mid-packet, else the rr winner
  always_comb begin
    sel_oh  = rr_grant;
    sel_idx = rr_idx;
    if (state == ARB_XFER) begin
      sel_oh  = NUM_PORTS'(1) << lock;
      sel_idx = lock;
    end
    can_load = !arb__sb__valid || sb__arb__ready;
    arb__mgr__ready = (reset_poweron || !can_load) ? '0 : sel_oh;
    take     = arb__mgr__ready & mgr__arb__valid;
    accept   = |take;
    sel_cntl = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_oh[i]) begin
        sel_cntl = mgr__arb__cntl[2*i +: 2];
        sel_data = mgr__arb__data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    nxt_ptr = (int'(sel_idx) == NUM_PORTS - 1) ?
              '0 : sel_idx + PORT_ID_WIDTH'(1);
  end

  // output register: load on accept, drain when the bus takes it
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      arb__sb__valid <= 1'b0;
      arb__sb__cntl  <= '0;
      arb__sb__data  <= '0;
      arb__sb__port  <= '0;
    end else if (accept) begin
      arb__sb__valid <= 1'b1;
      arb__sb__cntl  <= sel_cntl;
      arb__sb__data  <= sel_data;
      arb__sb__port  <= sel_idx;
    end else if (sb__arb__ready) begin
      arb__sb__valid <= 1'b0;
    end
  end

  // packet lock FSM; pointer moves past the winner on every EOP
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      lock  <= '0;
    end else if (accept) begin
      if (cntl_eop(sel_cntl)) begin
        state <= ARB_IDLE;
        ptr   <= nxt_ptr;
      end else if (state == ARB_IDLE) begin
        state <= ARB_XFER;
        lock  <= sel_idx;
      end
    end
  end

  assign arb__sys__busy = (state == ARB_XFER) || arb__sb__valid;

`ifdef STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt [NUM_PORTS];

  // per-port count of accepted EOP beats, free-running wrap
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
    end else if (cntl_eop(sel_cntl)) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (take[i]) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
      end
    end
  end

  // flatten counters onto the status bus
  always_comb begin
    arb__sys__pkt_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb__sys__pkt_cnt[i*16 +: 16] = pkt_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_stack_bus_downstream_arbiter.sv
// Directed bench for the stack-bus downstream arbiter.
// Manager queues feed the DUT; the stack-bus side is logged and compared.
module tb_stack_bus_downstream_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            reset_poweron;
  logic [NP-1:0]   valid;
  logic [2*NP-1:0] cntl;
  logic [NP*DW-1:0] data;
  logic [NP-1:0]   ready;
  logic            sb_valid;
  logic [1:0]      sb_cntl;
  logic [DW-1:0]   sb_data;
  logic [PW-1:0]   sb_port;
  logic            sb_ready;
  logic            busy;
`ifdef STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN
  logic [NP*16-1:0] pkt_cnt;
`endif

  int n_checks;
  int n_errors;
  int cyc;

  logic [1:0]  qc [NP][$];
  logic [63:0] qd [NP][$];

  int          rx_port [$];
  logic [63:0] rx_data [$];
  logic [1:0]  rx_cntl [$];
  int          rx_cyc  [$];

  always #10 clk = ~clk;

  stack_bus_downstream_arbiter #(
    .NUM_PORTS     (NP),
    .DATA_WIDTH    (DW),
    .PORT_ID_WIDTH (PW)
  ) dut (
    .clk               (clk),
    .reset_poweron     (reset_poweron),
    .mgr__arb__valid   (valid),
    .mgr__arb__cntl    (cntl),
    .mgr__arb__data    (data),
    .arb__mgr__ready   (ready),
    .arb__sb__valid    (sb_valid),
    .arb__sb__cntl     (sb_cntl),
    .arb__sb__data     (sb_data),
    .arb__sb__port     (sb_port),
    .sb__arb__ready    (sb_ready),
    .arb__sys__busy    (busy)
`ifdef STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN
    ,
    .arb__sys__pkt_cnt (pkt_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [1:0] c,
                      input logic [63:0] d);
    qc[p].push_back(c);
    qd[p].push_back(d);
  endtask

  task automatic clear_q();
    for (int p = 0; p < NP; p++) begin
      qc[p].delete();
      qd[p].delete();
    end
  endtask

  task automatic rx_clear();
    rx_port.delete();
    rx_data.delete();
    rx_cntl.delete();
    rx_cyc.delete();
  endtask

  task automatic drive();
    valid = '0;
    cntl  = '0;
    data  = '0;
    for (int p = 0; p < NP; p++) begin
      if (qc[p].size() != 0) begin
        valid[p]        = 1'b1;
        cntl[2*p +: 2]  = qc[p][0];
        data[p*DW +: DW] = qd[p][0];
      end
    end
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic tick();
    logic [NP-1:0] acc;
    @(negedge clk);
    acc = valid & ready;
    if (sb_valid && sb_ready) begin
      rx_port.push_back(int'(sb_port));
      rx_data.push_back(sb_data);
      rx_cntl.push_back(sb_cntl);
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        void'(qc[p].pop_front());
        void'(qd[p].pop_front());
      end
    end
    drive();
    #1;
  endtask

  task automatic check_rx_ports(input string tag, input int ep[$]);
    check({tag, "_count"}, 64'(rx_port.size()), 64'(ep.size()));
    for (int i = 0; i < ep.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), 64'(rx_port[i]), 64'(ep[i]));
    end
  endtask

  initial begin
    int dead_cnt;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset_poweron = 1'b1;
    sb_ready = 1'b1;
    clear_q();
    rx_clear();

    // reset: outputs low even with a SOP offered
    push(0, 2'b11, 64'h55);
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 0);
    check("rst_valid", 64'(sb_valid), 0);
    check("rst_cntl", 64'(sb_cntl), 0);
    check("rst_data", sb_data, 0);
    check("rst_port", 64'(sb_port), 0);
    check("rst_busy", 64'(busy), 0);
    clear_q();
    apply();
    reset_poweron = 1'b0;
    #1;

    // four 3-beat packets offered together
    rx_clear();
    cyc = 0;
    for (int p = 0; p < NP; p++) begin
      push(p, 2'b01, 64'(p*16 + 0));
      push(p, 2'b00, 64'(p*16 + 1));
      push(p, 2'b10, 64'(p*16 + 2));
    end
    apply();
    check("t1_ready_c0", 64'(ready), 'h1);
    repeat (12) tick();
    check("t1_busy_c12", 64'(busy), 1);
    tick();
    check("t1_busy_c13", 64'(busy), 0);
    check("t1_count", 64'(rx_port.size()), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_port_%0d", i), 64'(rx_port[i]), 64'(i/3));
      check($sformatf("t1_data_%0d", i), rx_data[i], 64'((i/3)*16 + i%3));
      check($sformatf("t1_cyc_%0d", i), 64'(rx_cyc[i]), 64'(i + 1));
    end

    // pointer 2 with ports 0 and 3 single-beat
    rx_clear();
    push(1, 2'b11, 64'h21);
    apply();
    check("t2_p1_ready", 64'(ready), 'h2);
    tick();
    push(0, 2'b11, 64'h30);
    push(3, 2'b11, 64'h33);
    apply();
    check("t2_ptr2_ready", 64'(ready), 'h8);
    tick();
    check("t2_p0_next", 64'(ready), 'h1);
    tick();
    push(0, 2'b11, 64'h40);
    push(1, 2'b11, 64'h41);
    apply();
    check("t2_ptr1_ready", 64'(ready), 'h2);
    tick();
    check("t2_p0_last", 64'(ready), 'h1);
    tick();
    tick();
    check_rx_ports("t2_rx", '{1, 3, 0, 1, 0});

    // MOP in IDLE is ignored; XFER lock holds off port 0
    rx_clear();
    push(2, 2'b00, 64'h77);
    apply();
    check("t3_mop_idle", 64'(ready), 0);
    tick();
    check("t3_mop_idle2", 64'(ready), 0);
    clear_q();
    push(1, 2'b01, 64'h51);
    push(1, 2'b00, 64'h52);
    push(1, 2'b10, 64'h53);
    apply();
    check("t3_p1_sop", 64'(ready), 'h2);
    tick();
    push(0, 2'b11, 64'h50);
    apply();
    check("t3_lock_c1", 64'(ready), 'h2);
    tick();
    check("t3_lock_c2", 64'(ready), 'h2);
    tick();
    check("t3_p0_next", 64'(ready), 'h1);
    tick();
    tick();
    check_rx_ports("t3_rx", '{1, 1, 1, 0});
    check("t3_last_data", rx_data[3], 64'h50);

    // stack bus stalls for 5 cycles on a held beat
    rx_clear();
    push(2, 2'b11, 64'hDEAD_BEEF);
    apply();
    tick();
    sb_ready = 1'b0;
    push(3, 2'b11, 64'h44);
    apply();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", 64'(sb_valid), 1);
      check("t4_hold_data", sb_data, 64'hDEAD_BEEF);
      check("t4_hold_port", 64'(sb_port), 2);
      check("t4_hold_cntl", 64'(sb_cntl), 3);
      check("t4_hold_ready", 64'(ready), 0);
      tick();
    end
    sb_ready = 1'b1;
    apply();
    check("t4_resume", 64'(ready), 'h8);
    tick();
    tick();
    dead_cnt = 0;
    foreach (rx_data[i]) if (rx_data[i] == 64'hDEAD_BEEF) dead_cnt++;
    check("t4_once", 64'(dead_cnt), 1);
    check("t4_rx_count", 64'(rx_data.size()), 2);

    // reset mid-packet drops it and clears the pointer
    rx_clear();
    push(0, 2'b11, 64'h60);
    apply();
    tick();
    push(1, 2'b01, 64'h61);
    push(1, 2'b00, 64'h62);
    push(1, 2'b00, 64'h63);
    push(1, 2'b10, 64'h64);
    apply();
    check("t5_p1_sop", 64'(ready), 'h2);
    tick();
    check("t5_beat2_ready", 64'(ready), 'h2);
    reset_poweron = 1'b1;
    #1;
    check("t5_rst_valid", 64'(sb_valid), 0);
    check("t5_rst_cntl", 64'(sb_cntl), 0);
    check("t5_rst_data", sb_data, 0);
    check("t5_rst_port", 64'(sb_port), 0);
    check("t5_rst_busy", 64'(busy), 0);
    check("t5_rst_ready", 64'(ready), 0);
    clear_q();
    apply();
    rx_clear();
    tick();
    reset_poweron = 1'b0;
    #1;
    check("t5_post_valid", 64'(sb_valid), 0);
    check("t5_post_busy", 64'(busy), 0);
    push(0, 2'b11, 64'h70);
    push(1, 2'b11, 64'h71);
    apply();
    check("t5_ptr0", 64'(ready), 'h1);
    tick();
    tick();
    tick();
    check_rx_ports("t5_rx", '{0, 1});
    check("t5_first_data", rx_data[0], 64'h70);

`ifdef STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN
    // 65537 single-beat packets from port 2 wrap its counter to 1
    reset_poweron = 1'b1;
    clear_q();
    apply();
    @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    #1;
    sb_ready = 1'b1;
    valid = 4'b0100;
    cntl  = 8'b0011_0000;
    data  = '0;
    repeat (65537) @(posedge clk);
    #1;
    valid = '0;
    cntl  = '0;
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("pkt_cnt_%0d", p), 64'(pkt_cnt[p*16 +: 16]),
            (p == 2) ? 64'd1 : 64'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_bus_downstream_arbiter.md
STACK_BUS_DOWNSTREAM_ARBITER -- requirements
Module: stack_bus_downstream_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, is the number of manager request ports (2..16).
REQ-002 Parameter DATA_WIDTH, default 64, is the payload width per beat.
REQ-003 Parameter PORT_ID_WIDTH, default 2, is the source-port tag width and SHALL equal clog2(NUM_PORTS).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1 (all logic on rising edge), then reset_poweron input 1 (asynchronous, active-high).
REQ-005 mgr__arb__valid input NUM_PORTS: per-port beat valid.
REQ-006 mgr__arb__cntl input 2*NUM_PORTS: per-port framing; 01 SOP, 00 MOP, 10 EOP, 11 single-beat SOP+EOP.
REQ-007 mgr__arb__data input NUM_PORTS*DATA_WIDTH: per-port beat payload.
REQ-008 arb__mgr__ready output NUM_PORTS: per-port beat accepted when valid&ready.
REQ-009 arb__sb__valid output 1, arb__sb__cntl output 2, arb__sb__data output DATA_WIDTH, arb__sb__port output PORT_ID_WIDTH: registered stream to the stack bus.
REQ-010 sb__arb__ready input 1: stack bus accepts a beat when valid&ready.
REQ-011 arb__sys__busy output 1: high while in XFER or while the output register holds a beat.

Function
REQ-012 FSM states IDLE and XFER; reset state IDLE.
REQ-013 In IDLE, the eligible ports are those with valid=1 and cntl SOP bit (bit0)=1; the grant goes to the first eligible port at or after the round-robin pointer, wrapping NUM_PORTS-1 -> 0.
REQ-014 A port presenting valid without SOP in IDLE is not eligible, and its ready SHALL stay 0.
REQ-015 Only the granted port SHALL see ready=1, and only when the output register is empty or sb__arb__ready=1; all other ready bits are 0.
REQ-016 An accepted SOP beat without EOP moves IDLE->XFER and locks the grant to that port.
REQ-017 In XFER, only the locked port is served; acceptance of its EOP beat returns XFER->IDLE.
REQ-018 Upon acceptance of any EOP beat (including 11), the pointer becomes granted port+1 modulo NUM_PORTS.
REQ-019 A single-beat 11 packet keeps the FSM in IDLE.
REQ-020 Latency: a beat accepted in cycle N appears on arb__sb__* in cycle N+1; throughput is one beat per cycle with no bubble between packets from different ports.
REQ-021 While arb__sb__valid=1 and sb__arb__ready=0, arb__sb__valid/cntl/data/port SHALL remain stable.
REQ-022 arb__sb__port SHALL carry the source port index of the beat in the output register.
REQ-023 Beats from different ports SHALL never interleave within a packet.

Reset
REQ-024 While reset_poweron=1: all outputs 0, state IDLE, pointer 0, output register empty.
REQ-025 Reset asserted mid-packet discards the partial packet; no EOP is synthesised.

Configuration
REQ-026 With STACK_BUS_DOWNSTREAM_ARB_PKT_CNT_EN defined, arb__sys__pkt_cnt is present as output NUM_PORTS*16: per-port count of EOP beats accepted, wrapping 16'hFFFF->0, reset 0.
REQ-027 Without the macro, the port and the counters are absent, and all other behaviour is identical.

Structure
REQ-028 The framing encodings (SOP/MOP/EOP/SOP+EOP), the FSM state encoding and the default widths SHALL live in the shared package stack_bus_pkg.
REQ-029 Pointer-based grant selection SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot grant plus index).

Verification
REQ-030 Ports 0-3 each offer a 3-beat packet in cycle 0, with sb ready=1 -> output port order 0,1,2,3; 12 contiguous beats in cycles 1-12; busy falls in cycle 13.
REQ-031 Pointer=2 with ports 0 and 3 requesting single-beat 11 packets -> port 3 is served first, then port 0; pointer ends at 1.
REQ-032 Port 1 is mid-packet (XFER) when port 0 raises SOP -> port 0 ready stays 0 until port 1 EOP is accepted; port 0 is served next.
REQ-033 sb__arb__ready is held 0 for 5 cycles with data 64'hDEAD_BEEF registered -> outputs are stable for the 5 cycles, all mgr ready bits are 0, and the beat is delivered once.
REQ-034 reset_poweron is pulsed during beat 2 of 4 -> all outputs are 0 immediately, and after release the next SOP from port 0 is granted with pointer 0.
REQ-035 With the macro defined, port 2 sends 65537 single-beat packets -> arb__sys__pkt_cnt[port 2]=1, and all other counters are 0.
